// File: rtl/pwm_command_ramp.sv
// pwm_command_ramp: clamps target duty commands and slews the PWM command once per trigger.
module pwm_command_ramp #(
  parameter int DATA_WIDTH       = 16,
  parameter int LIMIT            = 95,
  parameter int SLEW_STEP        = 4,
  parameter int TIMEOUT_TRIGGERS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trigger,
  input  logic                  fault,
  input  logic [DATA_WIDTH-1:0] target_sink_data,
  input  logic                  target_sink_valid,
  output logic [DATA_WIDTH-1:0] pwm_source_data,
  output logic                  pwm_source_valid,
  output logic                  status_timeout,
  output logic                  status_saturated
);
  localparam int CW = $clog2(TIMEOUT_TRIGGERS + 1);
  localparam logic signed [DATA_WIDTH-1:0] LIM = DATA_WIDTH'(LIMIT);
  localparam logic signed [DATA_WIDTH:0] STEP = (DATA_WIDTH + 1)'(SLEW_STEP);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_TRIGGERS);
  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
  state_t state_q, state_d;
  logic signed [DATA_WIDTH-1:0] target_q, target_d, current_q, current_d, data_q, data_d, tgt_in, goal;
  logic signed [DATA_WIDTH:0] goal_x, cur_x, diff, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, sat_q, sat_d, over, under;
  always_ff @(posedge clk)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (trigger ? CALC : IDLE) : (state_q == CALC) ? EMIT : IDLE;
  always_comb begin
    tgt_in    = signed'(target_sink_data);
    over      = tgt_in > LIM;
    under     = tgt_in < -LIM;
    target_d  = target_sink_valid ? (over ? LIM : under ? -LIM : tgt_in) : target_q;
    sat_d     = target_sink_valid ? (over | under) : sat_q;
    cnt_d     = target_sink_valid ? '0 :
                (state_q == IDLE && trigger && cnt_q != TMO) ? cnt_q + 1'b1 : cnt_q;
    // Timed-out target is treated as zero but still ramped at the slew rate
    goal      = status_timeout ? '0 : target_q;
    goal_x    = {goal[DATA_WIDTH-1], goal};
    cur_x     = {current_q[DATA_WIDTH-1], current_q};
    diff      = goal_x - cur_x;
    step      = diff > STEP ? STEP : diff < -STEP ? -STEP : diff;
    current_d = (state_q != CALC) ? current_q : fault ? '0 : DATA_WIDTH'(cur_x + step);
    data_d    = (state_q == CALC) ? current_d : data_q;
    valid_d   = state_q == CALC;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      target_q  <= '0;
      current_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  assign pwm_source_data  = data_q;
  assign pwm_source_valid = valid_q;
  assign status_timeout   = cnt_q == TMO;
  assign status_saturated = sat_q;
endmodule

// File: tb/tb_pwm_command_ramp.sv
// tb_pwm_command_ramp: directed and random checks of pwm_command_ramp against a per-trigger ramp model.
module tb_pwm_command_ramp;
  logic clk = 1'b0, reset_n = 1'b0, trigger = 1'b0, fault = 1'b0, target_sink_valid = 1'b0;
  logic [15:0] target_sink_data = '0, pwm_source_data;
  logic pwm_source_valid, status_timeout, status_saturated;
  int n_chk = 0, n_fail = 0;
  int m_tgt = 0, m_cur = 0, m_out = 0, m_cnt = 0, m_busy = 0;
  bit m_sat = 0, m_valid = 0;
  always #5 clk = ~clk;
  pwm_command_ramp dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .fault(fault),
    .target_sink_data(target_sink_data), .target_sink_valid(target_sink_valid),
    .pwm_source_data(pwm_source_data), .pwm_source_valid(pwm_source_valid),
    .status_timeout(status_timeout), .status_saturated(status_saturated)
  );
  function automatic int lim(input int x, input int l);
    return x > l ? l : x < -l ? -l : x;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  // One clock: drive inputs, advance the reference model, then compare every output
  task automatic step(input bit r, input bit t, input bit v, input logic [15:0] d, input bit f);
    int g;
    reset_n = r; trigger = t; target_sink_valid = v; target_sink_data = d; fault = f;
    @(posedge clk);
    m_valid = 0;
    if (!r) begin
      m_tgt = 0; m_cur = 0; m_out = 0; m_cnt = 0; m_busy = 0; m_sat = 0;
    end else begin
      if (m_busy == 1) begin
        g = (m_cnt == 8) ? 0 : m_tgt;
        m_cur = f ? 0 : m_cur + lim(g - m_cur, 4);
        m_out = m_cur; m_valid = 1; m_busy = 2;
      end else if (m_busy == 2) m_busy = 0;
      else if (t) begin
        m_busy = 1;
        if (m_cnt < 8) m_cnt++;
      end
      if (v) begin
        m_tgt = lim(int'($signed(d)), 95);
        m_sat = (int'($signed(d)) > 95) || (int'($signed(d)) < -95);
        m_cnt = 0;
      end
    end
    #1;
    chk("data", pwm_source_data, 16'(m_out));
    chk("valid", {15'b0, pwm_source_valid}, {15'b0, m_valid});
    chk("timeout", {15'b0, status_timeout}, {15'b0, m_cnt == 8});
    chk("saturated", {15'b0, status_saturated}, {15'b0, m_sat});
  endtask
  task automatic trig_emit(input int exp, input bit v, input logic [15:0] d, input bit f);
    step(1, 1, v, d, f);
    step(1, 0, 0, 0, f);
    chk("emit_valid", {15'b0, pwm_source_valid}, 16'd1);
    chk("emit_data", pwm_source_data, 16'(exp));
    step(1, 0, 0, 0, f);
  endtask
  initial begin
    bit r, t, v, f;
    logic [15:0] d;
    int vcount;
    step(0, 1, 1, 16'd50, 0);
    step(0, 0, 0, 0, 0);
    chk("reset_data", pwm_source_data, 16'd0);
    step(1, 0, 1, 16'd10, 0);
    trig_emit(4, 0, 0, 0); trig_emit(8, 0, 0, 0); trig_emit(10, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 16'd200, 0);
    chk("sat_hi", {15'b0, status_saturated}, 16'd1);
    for (int i = 1; i <= 23; i++) trig_emit(4 * i, 1, 16'd200, 0);
    trig_emit(95, 1, 16'd200, 0);
    trig_emit(95, 1, 16'd200, 0);
    step(1, 0, 1, -16'sd30, 0);
    chk("sat_lo", {15'b0, status_saturated}, 16'd0);
    for (int i = 1; i <= 31; i++) trig_emit(95 - 4 * i, 1, -16'sd30, 0);
    trig_emit(-30, 1, -16'sd30, 0);
    trig_emit(-30, 1, -16'sd30, 0);
    step(1, 0, 1, 16'h8000, 0);
    chk("most_neg_sat", {15'b0, status_saturated}, 16'd1);
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) trig_emit(4 * i, 1, 16'd20, 0);
    step(1, 0, 1, 16'd20, 0);
    for (int i = 0; i < 7; i++) trig_emit(20, 0, 0, 0);
    chk("timeout_pre", {15'b0, status_timeout}, 16'd0);
    trig_emit(16, 0, 0, 0);
    chk("timeout_set", {15'b0, status_timeout}, 16'd1);
    trig_emit(12, 0, 0, 0); trig_emit(8, 0, 0, 0); trig_emit(4, 0, 0, 0);
    trig_emit(0, 0, 0, 0); trig_emit(0, 0, 0, 0);
    step(1, 0, 1, 16'd5, 0);
    chk("timeout_clear", {15'b0, status_timeout}, 16'd0);
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) trig_emit(4 * i, 1, 16'd60, 0);
    trig_emit(0, 1, 16'd60, 1);
    trig_emit(4, 1, 16'd60, 0);
    trig_emit(8, 1, 16'd60, 0);
    vcount = 0;
    step(1, 1, 0, 0, 0); vcount += int'(pwm_source_valid);
    step(1, 1, 0, 0, 0); vcount += int'(pwm_source_valid);
    step(1, 0, 0, 0, 0); vcount += int'(pwm_source_valid);
    step(1, 0, 0, 0, 0); vcount += int'(pwm_source_valid);
    step(1, 0, 0, 0, 0); vcount += int'(pwm_source_valid);
    chk("double_trigger_strobes", 16'(vcount), 16'd1);
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) trig_emit(4 * i, 1, 16'd40, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_calc_valid", {15'b0, pwm_source_valid}, 16'd0);
    chk("rst_calc_data", pwm_source_data, 16'd0);
    step(1, 0, 0, 0, 0);
    chk("rst_calc_no_strobe", {15'b0, pwm_source_valid}, 16'd0);
    trig_emit(4, 1, 16'd12, 0);
    trig_emit(8, 0, 0, 0);
    trig_emit(12, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99) != 0;
      t = $urandom_range(0, 2) == 0;
      v = $urandom_range(0, 6) == 0;
      f = $urandom_range(0, 9) == 0;
      d = ($urandom_range(0, 9) == 0) ? 16'h8000 :
          ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 240)) - 120);
      step(r, t, v, d, f);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_command_ramp.md
PWM_COMMAND_RAMP -- requirements
Module: pwm_command_ramp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of the signed two's-complement command words.
REQ-002 SHALL have parameter LIMIT, default 95, meaning the maximum output magnitude (matches the pwm_driver PWM_MAX_ON_CYCLES).
REQ-003 SHALL have parameter SLEW_STEP, default 4, meaning the maximum output change per trigger.
REQ-004 SHALL have parameter TIMEOUT_TRIGGERS, default 8, meaning the number of triggers without a new target before the target is forced to 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port trigger, input, 1 bit: a single-cycle pulse marking the PWM period start.
REQ-008 SHALL have port fault, input, 1 bit: level input that forces a zero command.
REQ-009 SHALL have port target_sink_data, input, DATA_WIDTH bits: the signed target duty command.
REQ-010 SHALL have port target_sink_valid, input, 1 bit: target qualifier; the block is always ready.
REQ-011 SHALL have port pwm_source_data, output, DATA_WIDTH bits: the signed command feeding pwm_driver pwm_sink_data.
REQ-012 SHALL have port pwm_source_valid, output, 1 bit: a single-cycle strobe feeding pwm_driver pwm_sink_valid.
REQ-013 SHALL have port status_timeout, output, 1 bit: 1 while the target is forced to 0 by the timeout.
REQ-014 SHALL have port status_saturated, output, 1 bit: 1 when the last accepted target was clamped to ±LIMIT.

Function
REQ-015 SHALL capture target_sink_data on every cycle that target_sink_valid=1, clamping it to [-LIMIT, +LIMIT]; the most negative input (-32768 at default width) SHALL give -LIMIT.
REQ-016 SHALL set status_saturated on each accepted target according to whether that target was clamped, and SHALL hold it until the next accepted target.
REQ-017 SHALL use a three-state FSM: IDLE, CALC, EMIT; the only transitions SHALL be IDLE->CALC on trigger=1, CALC->EMIT unconditionally, and EMIT->IDLE unconditionally.
REQ-018 SHALL, in CALC, compute diff = target - current in DATA_WIDTH+1 bits, clamp diff to [-SLEW_STEP, +SLEW_STEP], and add it to current; current SHALL never leave [-LIMIT, +LIMIT].
REQ-019 SHALL, in EMIT, drive pwm_source_data=current and pwm_source_valid=1 for exactly one cycle; a trigger at cycle t SHALL give valid at cycle t+2.
REQ-020 SHALL hold pwm_source_data at its last emitted value while pwm_source_valid=0.
REQ-021 SHALL ignore trigger pulses arriving in CALC or EMIT, with no queuing.
REQ-022 SHALL, when target_sink_valid and trigger occur in the same cycle, use the newly captured target in that period's CALC.
REQ-023 SHALL count triggers accepted in IDLE since the last accepted target, saturating at TIMEOUT_TRIGGERS; any accepted target SHALL clear the count and status_timeout.
REQ-024 SHALL, when the count reaches TIMEOUT_TRIGGERS, set status_timeout=1 and treat the target as 0 (ramped at SLEW_STEP), starting with the CALC of that trigger.
REQ-025 SHALL, while fault=1 during CALC, set current to 0 immediately with no slew, and still emit in EMIT.
REQ-026 SHALL, after fault deasserts, resume ramping from 0 toward the stored target.
REQ-027 SHALL, while fault=1, continue to accept and store targets.

Reset
REQ-028 SHALL, when reset_n=0 at a clock edge, set state=IDLE, current=0, target=0, pwm_source_data=0, pwm_source_valid=0, status_timeout=0, status_saturated=0, and timeout count=0.
REQ-029 SHALL, when reset_n=0 mid-operation (CALC or EMIT), abort the operation with no valid strobe on the following cycle.
REQ-030 SHALL ignore trigger and target_sink_valid while reset_n=0.

Verification (default parameters)
REQ-031 SHALL be verified by: after reset, target 10 followed by three triggers -> outputs 4, 8, 10, each valid exactly 2 cycles after its trigger.
REQ-032 SHALL be verified by: target 200 -> status_saturated=1; outputs ramp 4, 8, ..., 92, then 95 on the 24th trigger, and hold at 95.
REQ-033 SHALL be verified by: from current 95, target -30 -> outputs 91, 87, ... down to -29, then -30; status_saturated=0.
REQ-034 SHALL be verified by: from output 20 with no new target, 8 triggers -> status_timeout=1 at the 8th; outputs 16, 12, 8, 4, 0; a new target then clears status_timeout.
REQ-035 SHALL be verified by: fault=1 while at 60 -> the next emitted value is 0; after fault is released, outputs are 4, 8, ...; a trigger arriving 1 cycle after another -> only one valid strobe.
REQ-036 SHALL be verified by: reset_n=0 for 1 cycle while in CALC at 40 -> no strobe follows, and all outputs are 0; the same-cycle target+trigger case -> the new target is used.
